// File: rtl/cpu_sequencer_if.sv
// Memory-side handshake for the instruction sequencer.
// The sequencer drives the command and address source, and memory answers with ready.
interface cpu_sequencer_if;
  logic [1:0] mem_cmd;
  logic       addr_sel;
  logic       mem_ready;

  modport master (
    output mem_cmd,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_cmd,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Self-fetching Moore sequencer for the Simple RISC Machine datapath.
// Covers fetch, ALU, LDR/STR with wait-state timeout, HALT and a sticky error state.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit HALT_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            opcode,
  input  logic [1:0]            op,
  cpu_sequencer_if.master       mem,
  output logic [2:0]            nsel,
  output logic [3:0]            vsel,
  output logic                  asel,
  output logic                  bsel,
  output logic                  loada,
  output logic                  loadb,
  output logic                  loadc,
  output logic                  loads,
  output logic                  write,
  output logic                  load_ir,
  output logic                  load_pc,
  output logic                  reset_pc,
  output logic                  load_addr,
  output logic                  halted,
  output logic                  err,
  output logic [1:0]            err_cause,
  output logic [4:0]            state_o
);

  typedef enum logic [4:0] {
    S_RST  = 5'd0,
    S_IF1  = 5'd1,
    S_IF2  = 5'd2,
    S_UPC  = 5'd3,
    S_DEC  = 5'd4,
    S_IMM  = 5'd5,
    S_GETA = 5'd6,
    S_GETB = 5'd7,
    S_EXEC = 5'd8,
    S_WB   = 5'd9,
    S_ADDR = 5'd10,
    S_LDA  = 5'd11,
    S_GETD = 5'd12,
    S_MOVD = 5'd13,
    S_MRD  = 5'd14,
    S_LDWB = 5'd15,
    S_MWR  = 5'd16,
    S_HALT = 5'd17,
    S_ERR  = 5'd18
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    cause_nxt;
  logic [CW-1:0] cnt;
  logic          in_wait;
  logic          tmo;

  logic is_alu;
  logic is_ldr;
  logic is_cmp;
  logic is_movr;
  logic is_mvn;
  logic is_mem;

  assign is_alu  = (opcode == 3'b101);
  assign is_ldr  = (opcode == 3'b011);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_mem  = ((opcode == 3'b011) || (opcode == 3'b100))
                   && (op == 2'b00);

  assign in_wait = (state == S_IF1) || (state == S_MRD)
                   || (state == S_MWR);
  // The wait is cut off on its last allowed cycle unless ready arrives then.
  assign tmo = in_wait && !mem.mem_ready
               && (MEM_TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RST;
      cnt       <= '0;
      err_cause <= 2'b00;
    end else begin
      state <= state_nxt;
      if (in_wait && (state_nxt == state))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if ((state != S_ERR) && (state_nxt == S_ERR))
        err_cause <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = 2'b00;
    unique case (state)
      S_RST: state_nxt = S_IF1;
      S_IF1: begin
        if (mem.mem_ready) begin
          state_nxt = S_IF2;
        end else if (tmo) begin
          state_nxt = S_ERR;
          cause_nxt = 2'b10;
        end
      end
      S_IF2: state_nxt = S_UPC;
      S_UPC: state_nxt = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          (opcode == 3'b110) && (op == 2'b10):
            state_nxt = S_IMM;
          is_movr, is_mvn:
            state_nxt = S_GETB;
          is_alu && (op != 2'b11), is_mem:
            state_nxt = S_GETA;
          (opcode == 3'b111):
            state_nxt = HALT_EN ? S_HALT : S_IF1;
          default: begin
            state_nxt = S_ERR;
            cause_nxt = 2'b01;
          end
        endcase
      end
      S_IMM:  state_nxt = S_IF1;
      S_GETA: state_nxt = is_alu ? S_GETB : S_ADDR;
      S_GETB: state_nxt = S_EXEC;
      S_EXEC: state_nxt = is_cmp ? S_IF1 : S_WB;
      S_WB:   state_nxt = S_IF1;
      S_ADDR: state_nxt = S_LDA;
      S_LDA:  state_nxt = is_ldr ? S_MRD : S_GETD;
      S_GETD: state_nxt = S_MOVD;
      S_MOVD: state_nxt = S_MWR;
      S_MRD, S_MWR: begin
        if (mem.mem_ready) begin
          state_nxt = (state == S_MRD) ? S_LDWB : S_IF1;
        end else if (tmo) begin
          state_nxt = S_ERR;
          cause_nxt = 2'b10;
        end
      end
      S_LDWB: state_nxt = S_IF1;
      S_HALT: state_nxt = S_HALT;
      S_ERR:  state_nxt = S_ERR;
      default: begin
        state_nxt = S_ERR;
        cause_nxt = 2'b01;
      end
    endcase
  end

  always_comb begin
    nsel         = 3'b000;
    vsel         = 4'b0000;
    asel         = 1'b0;
    bsel         = 1'b0;
    loada        = 1'b0;
    loadb        = 1'b0;
    loadc        = 1'b0;
    loads        = 1'b0;
    write        = 1'b0;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    reset_pc     = 1'b0;
    load_addr    = 1'b0;
    halted       = 1'b0;
    err          = 1'b0;
    mem.addr_sel = 1'b0;
    mem.mem_cmd  = 2'b00;
    unique case (state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        mem.addr_sel = 1'b1;
        mem.mem_cmd  = 2'b01;
      end
      S_IF2: begin
        mem.addr_sel = 1'b1;
        mem.mem_cmd  = 2'b01;
        load_ir      = 1'b1;
      end
      S_UPC: load_pc = 1'b1;
      S_IMM: begin
        nsel  = 3'b001;
        vsel  = 4'b0010;
        write = 1'b1;
      end
      S_GETA: begin
        nsel  = 3'b001;
        loada = 1'b1;
      end
      S_GETB: begin
        nsel  = 3'b010;
        loadb = 1'b1;
      end
      S_EXEC: begin
        loadc = 1'b1;
        asel  = is_movr || is_mvn;
        loads = is_cmp;
      end
      S_WB: begin
        nsel  = 3'b100;
        vsel  = 4'b1000;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LDA: load_addr = 1'b1;
      S_GETD: begin
        nsel  = 3'b100;
        loadb = 1'b1;
      end
      S_MOVD: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MRD: mem.mem_cmd = 2'b01;
      S_LDWB: begin
        mem.mem_cmd = 2'b01;
        nsel        = 3'b100;
        vsel        = 4'b0001;
        write       = 1'b1;
      end
      S_MWR:  mem.mem_cmd = 2'b10;
      S_HALT: halted = 1'b1;
      S_ERR:  err = 1'b1;
      default: err = 1'b1;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench: u0 has a short timeout and HALT enabled,
// u1 has the default timeout and treats 111 as a NOP.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b101;
  logic [1:0] op = 2'b00;
  logic       mem_ready = 1'b1;

  always #5 clk = ~clk;

  cpu_sequencer_if bus0();
  cpu_sequencer_if bus1();
  assign bus0.mem_ready = mem_ready;
  assign bus1.mem_ready = mem_ready;

  logic [2:0] nsel0, nsel1;
  logic [3:0] vsel0, vsel1;
  logic asel0, bsel0, loada0, loadb0, loadc0, loads0, write0;
  logic asel1, bsel1, loada1, loadb1, loadc1, loads1, write1;
  logic load_ir0, load_pc0, reset_pc0, load_addr0, halted0, err0;
  logic load_ir1, load_pc1, reset_pc1, load_addr1, halted1, err1;
  logic [1:0] cause0, cause1;
  logic [4:0] st0, st1;

  cpu_sequencer #(.MEM_TIMEOUT(4), .HALT_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .mem(bus0),
    .nsel(nsel0), .vsel(vsel0), .asel(asel0), .bsel(bsel0),
    .loada(loada0), .loadb(loadb0), .loadc(loadc0),
    .loads(loads0), .write(write0), .load_ir(load_ir0),
    .load_pc(load_pc0), .reset_pc(reset_pc0),
    .load_addr(load_addr0), .halted(halted0), .err(err0),
    .err_cause(cause0), .state_o(st0)
  );

  cpu_sequencer #(.MEM_TIMEOUT(15), .HALT_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .mem(bus1),
    .nsel(nsel1), .vsel(vsel1), .asel(asel1), .bsel(bsel1),
    .loada(loada1), .loadb(loadb1), .loadc(loadc1),
    .loads(loads1), .write(write1), .load_ir(load_ir1),
    .load_pc(load_pc1), .reset_pc(reset_pc1),
    .load_addr(load_addr1), .halted(halted1), .err(err1),
    .err_cause(cause1), .state_o(st1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic st(input string tag,
                    input logic [4:0] e0,
                    input logic [4:0] e1);
    step();
    chk({tag, "_u0"}, 32'(st0), 32'(e0));
    chk({tag, "_u1"}, 32'(st1), 32'(e1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_st", 32'(st0), 32'd0);
    chk("rst_rpc", 32'(reset_pc0), 32'd1);
    chk("rst_lpc", 32'(load_pc0), 32'd1);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_cause", 32'(cause0), 32'd0);
    chk("rst_cmd", 32'(bus0.mem_cmd), 32'd0);

    // ADD 101/00
    st("add", 5'd1, 5'd1);
    chk("if1_cmd", 32'(bus0.mem_cmd), 32'd1);
    chk("if1_asel", 32'(bus0.addr_sel), 32'd1);
    st("add", 5'd2, 5'd2);
    chk("if2_ir", 32'(load_ir0), 32'd1);
    st("add", 5'd3, 5'd3);
    chk("upc_lpc", 32'(load_pc0), 32'd1);
    st("add", 5'd4, 5'd4);
    st("add", 5'd6, 5'd6);
    chk("geta", 32'({nsel0, loada0}), 32'b0011);
    st("add", 5'd7, 5'd7);
    chk("getb", 32'({nsel0, loadb0}), 32'b0101);
    st("add", 5'd8, 5'd8);
    chk("exec", 32'({loadc0, asel0, loads0}), 32'b100);
    st("add", 5'd9, 5'd9);
    chk("wb", 32'({nsel0, vsel0, write0}), 32'b100_1000_1);
    st("add", 5'd1, 5'd1);

    // MOV imm 110/10: IF1 again five cycles after IF1
    opcode = 3'b110; op = 2'b10;
    st("imm", 5'd2, 5'd2);
    st("imm", 5'd3, 5'd3);
    st("imm", 5'd4, 5'd4);
    st("imm", 5'd5, 5'd5);
    chk("imm_out", 32'({nsel0, vsel0, write0}), 32'b001_0010_1);
    st("imm", 5'd1, 5'd1);

    // LDR 011/00 with 3 wait cycles in MRD
    opcode = 3'b011; op = 2'b00;
    st("ldr", 5'd2, 5'd2);
    st("ldr", 5'd3, 5'd3);
    st("ldr", 5'd4, 5'd4);
    st("ldr", 5'd6, 5'd6);
    st("ldr", 5'd10, 5'd10);
    chk("addr", 32'({bsel0, loadc0}), 32'b11);
    st("ldr", 5'd11, 5'd11);
    chk("lda", 32'(load_addr0), 32'd1);
    st("ldr", 5'd14, 5'd14);
    chk("mrd_cmd", 32'({bus0.mem_cmd, bus0.addr_sel}), 32'b010);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) st("mrd_w", 5'd14, 5'd14);
    mem_ready = 1'b1;
    st("ldwb", 5'd15, 5'd15);
    chk("ldwb_out", 32'({nsel0, vsel0, write0}), 32'b100_0001_1);
    chk("ldwb_cmd", 32'(bus0.mem_cmd), 32'd1);
    st("ldr", 5'd1, 5'd1);

    // STR 100/00
    opcode = 3'b100;
    st("str", 5'd2, 5'd2);
    st("str", 5'd3, 5'd3);
    st("str", 5'd4, 5'd4);
    st("str", 5'd6, 5'd6);
    st("str", 5'd10, 5'd10);
    st("str", 5'd11, 5'd11);
    st("str", 5'd12, 5'd12);
    chk("getd", 32'({nsel0, loadb0}), 32'b1001);
    st("str", 5'd13, 5'd13);
    chk("movd", 32'({asel0, loadc0}), 32'b11);
    st("str", 5'd16, 5'd16);
    chk("mwr_cmd", 32'(bus0.mem_cmd), 32'd2);
    st("str", 5'd1, 5'd1);

    // CMP 101/01
    opcode = 3'b101; op = 2'b01;
    st("cmp", 5'd2, 5'd2);
    st("cmp", 5'd3, 5'd3);
    st("cmp", 5'd4, 5'd4);
    st("cmp", 5'd6, 5'd6);
    st("cmp", 5'd7, 5'd7);
    st("cmp", 5'd8, 5'd8);
    chk("cmp_ex", 32'({loadc0, asel0, loads0}), 32'b101);
    st("cmp", 5'd1, 5'd1);

    // MVN 101/11 skips GETA
    op = 2'b11;
    st("mvn", 5'd2, 5'd2);
    st("mvn", 5'd3, 5'd3);
    st("mvn", 5'd4, 5'd4);
    st("mvn", 5'd7, 5'd7);
    st("mvn", 5'd8, 5'd8);
    chk("mvn_ex", 32'({loadc0, asel0, loads0}), 32'b110);
    st("mvn", 5'd9, 5'd9);
    st("mvn", 5'd1, 5'd1);

    // reset in the middle of an MRD wait
    opcode = 3'b011; op = 2'b00;
    st("ldr2", 5'd2, 5'd2);
    st("ldr2", 5'd3, 5'd3);
    st("ldr2", 5'd4, 5'd4);
    st("ldr2", 5'd6, 5'd6);
    st("ldr2", 5'd10, 5'd10);
    st("ldr2", 5'd11, 5'd11);
    st("ldr2", 5'd14, 5'd14);
    mem_ready = 1'b0;
    st("mrd2_w", 5'd14, 5'd14);
    st("mrd2_w", 5'd14, 5'd14);
    do_reset();
    chk("mrst_st0", 32'(st0), 32'd0);
    chk("mrst_st1", 32'(st1), 32'd0);
    chk("mrst_rpc", 32'(reset_pc0), 32'd1);
    chk("mrst_err", 32'(err0), 32'd0);

    // fetch timeout: u0 after 4 cycles, u1 after 15
    for (int i = 0; i < 4; i++) st("tmo_if1", 5'd1, 5'd1);
    st("tmo_err", 5'd18, 5'd1);
    chk("tmo_err0", 32'(err0), 32'd1);
    chk("tmo_cause0", 32'(cause0), 32'd2);
    chk("tmo_err1", 32'(err1), 32'd0);
    for (int i = 0; i < 10; i++) st("tmo_long", 5'd18, 5'd1);
    st("tmo_err1", 5'd18, 5'd18);
    chk("tmo_cause1", 32'(cause1), 32'd2);

    // ready on the last allowed cycle completes the fetch
    do_reset();
    chk("clr_err", 32'(err0), 32'd0);
    chk("clr_cause", 32'(cause0), 32'd0);
    for (int i = 0; i < 4; i++) st("last_if1", 5'd1, 5'd1);
    mem_ready = 1'b1;
    st("last_if2", 5'd2, 5'd2);

    // illegal opcode
    opcode = 3'b000;
    do_reset();
    st("ill", 5'd1, 5'd1);
    st("ill", 5'd2, 5'd2);
    st("ill", 5'd3, 5'd3);
    st("ill", 5'd4, 5'd4);
    st("ill", 5'd18, 5'd18);
    chk("ill_cause0", 32'(cause0), 32'd1);
    chk("ill_cause1", 32'(cause1), 32'd1);
    for (int i = 0; i < 3; i++) st("ill_hold", 5'd18, 5'd18);

    // HALT vs NOP
    opcode = 3'b111;
    do_reset();
    st("hlt", 5'd1, 5'd1);
    st("hlt", 5'd2, 5'd2);
    st("hlt", 5'd3, 5'd3);
    st("hlt", 5'd4, 5'd4);
    st("hlt", 5'd17, 5'd1);
    chk("hlt_h1", 32'(halted1), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hlt_hold", 32'({st0, halted0}), 32'({5'd17, 1'b1}));
    end
    do_reset();
    chk("hlt_rst", 32'({st0, halted0}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
